// File: rtl/multiply_add.sv
// multiply_add: rebuilds a dividend as Q*D+R, the inverse of the
// 8/4 shift-subtract divider, using MSB-first shift-add.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      begin an operation (sampled only in IDLE)
//   quoteint   quotient operand Q, 4-bit unsigned
//   divisor    divisor operand D, 4-bit unsigned
//   remainder  remainder operand R, 8-bit unsigned
//   dividend   low 8 bits of Q*D+R, registered
//   overflow   bit 8 of Q*D+R, registered
//   busy       high in LOAD, ADD and SHIFT
//   done       one-cycle pulse in DONE
module multiply_add (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] quoteint,
  input  logic [3:0] divisor,
  input  logic [7:0] remainder,
  output logic [7:0] dividend,
  output logic       overflow,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nx;

  logic [8:0] acc;
  logic [3:0] q_reg;
  logic [3:0] d_reg;
  logic [1:0] idx;

  logic [7:0] dividend_q;
  logic       overflow_q;

  // Divisor weighted by the current quotient bit position.
  logic [8:0] addend;
  logic [8:0] acc_sum;
  logic       last_bit;

  assign addend   = {5'b0, d_reg} << idx;
  // Max result is 15*15+255 = 480, so 9 bits never wrap.
  assign acc_sum  = acc + addend;
  assign last_bit = (idx == 2'd0);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nx = S_ADD;
      end
      S_ADD: begin
        state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_bit) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_ADD;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= 9'd0;
      q_reg <= 4'd0;
      d_reg <= 4'd0;
      idx   <= 2'd0;
    end else begin
      unique case (state)
        S_LOAD: begin
          acc   <= {1'b0, remainder};
          q_reg <= quoteint;
          d_reg <= divisor;
          idx   <= 2'd3;
        end
        S_ADD: begin
          if (q_reg[idx]) begin
            acc <= acc_sum;
          end
        end
        S_SHIFT: begin
          if (!last_bit) begin
            idx <= idx - 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers only change on the SHIFT->DONE step, so
  // they hold through the next operation's LOAD/ADD/SHIFT.
  always_ff @(posedge clk) begin
    if (reset) begin
      dividend_q <= 8'd0;
      overflow_q <= 1'b0;
    end else if (state == S_SHIFT && last_bit) begin
      dividend_q <= acc[7:0];
      overflow_q <= acc[8];
    end
  end

  assign dividend = dividend_q;
  assign overflow = overflow_q;

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_LOAD:  busy = 1'b1;
      S_ADD:   busy = 1'b1;
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_multiply_add.sv
// tb_multiply_add: table-driven and sequence checks of multiply_add
// with a result scoreboard and latency/busy/pulse timing checks.
module tb_multiply_add;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] quoteint;
  logic [3:0] divisor;
  logic [7:0] remainder;
  logic [7:0] dividend;
  logic       overflow;
  logic       busy;
  logic       done;

  multiply_add dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .quoteint  (quoteint),
    .divisor   (divisor),
    .remainder (remainder),
    .dividend  (dividend),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] q;
    logic [3:0] d;
    logic [7:0] r;
    logic [7:0] div;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] div;
    logic       ovf;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] last_div;
  logic       last_ovf;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [7:0] dv, input logic ov);
    exp_t e;
    e.div = dv;
    e.ovf = ov;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " unexpected done"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, " dividend"}, int'(dividend), int'(e.div));
      check({tag, " overflow"}, int'(overflow), int'(e.ovf));
      last_div = e.div;
      last_ovf = e.ovf;
    end
  endtask

  // Caller is at a negedge. Start is sampled at the next posedge.
  task automatic run_op(input logic [3:0] q, input logic [3:0] d,
                        input logic [7:0] r, input logic [7:0] ediv,
                        input logic eovf, input bit repulse,
                        input string tag);
    int m;
    int bcnt;
    bit seen;
    quoteint  = q;
    divisor   = d;
    remainder = r;
    start     = 1'b1;
    push_exp(ediv, eovf);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bcnt  = busy ? 1 : 0;
    @(posedge clk);
    @(negedge clk);
    quoteint  = 4'($urandom_range(0, 15));
    divisor   = 4'($urandom_range(0, 15));
    remainder = 8'($urandom_range(0, 255));
    if (busy) bcnt++;
    check({tag, " hold"}, int'({last_ovf, dividend}),
          int'({last_ovf, last_div}));
    if (repulse) begin
      quoteint  = 4'd1;
      divisor   = 4'd1;
      remainder = 8'd1;
      start     = 1'b1;
    end
    m    = 1;
    seen = 1'b0;
    while (m < 25 && !seen) begin
      @(posedge clk);
      m++;
      @(negedge clk);
      if (repulse && m == 5) start = 1'b0;
      if (done) seen = 1'b1;
      else if (busy) bcnt++;
    end
    if (!seen) begin
      check({tag, " timeout"}, 0, 1);
      void'(sb.pop_front());
      start = 1'b0;
    end else begin
      check({tag, " latency"}, m, 9);
      check({tag, " busy cycles"}, bcnt, 9);
      pop_check(tag);
    end
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " done pulse"}, int'(done), 0);
      check({tag, " idle busy"}, int'(busy), 0);
    end
  endtask

  initial begin
    int t0;
    int t1;
    int ndone;
    int nn;
    int dd;
    logic [3:0] qq;
    logic [7:0] rr;

    vecs[0] = '{4'd5,  4'd3,  8'd2,   8'd17,  1'b0};
    vecs[1] = '{4'd15, 4'd15, 8'd255, 8'hE0,  1'b1};
    vecs[2] = '{4'd0,  4'd9,  8'd7,   8'd7,   1'b0};
    vecs[3] = '{4'd9,  4'd13, 8'd4,   8'd121, 1'b0};
    vecs[4] = '{4'd1,  4'd1,  8'd1,   8'd2,   1'b0};
    vecs[5] = '{4'd15, 4'd0,  8'd0,   8'd0,   1'b0};
    vecs[6] = '{4'd0,  4'd0,  8'd255, 8'd255, 1'b0};
    vecs[7] = '{4'd15, 4'd15, 8'd0,   8'hE1,  1'b0};
    vecs[8] = '{4'd8,  4'd15, 8'd136, 8'd0,   1'b1};
    vecs[9] = '{4'd10, 4'd6,  8'd200, 8'd4,   1'b1};

    reset     = 1'b1;
    start     = 1'b1;
    quoteint  = 4'd0;
    divisor   = 4'd0;
    remainder = 8'd0;
    last_div  = 8'd0;
    last_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset dividend", int'(dividend), 0);
    check("reset overflow", int'(overflow), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);

    // Start on the very first edge with reset low.
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].q, vecs[i].d, vecs[i].r, vecs[i].div,
             vecs[i].ovf, 1'b0, $sformatf("vec%0d", i));
    end

    run_op(4'd5, 4'd3, 8'd2, 8'd17, 1'b0, 1'b1, "repulse");

    // start held high: back-to-back every 11 cycles.
    quoteint  = 4'd3;
    divisor   = 4'd4;
    remainder = 8'd5;
    start     = 1'b1;
    push_exp(8'd17, 1'b0);
    push_exp(8'd50, 1'b0);
    @(posedge clk);
    @(negedge clk);
    t0    = cyc;
    t1    = 0;
    ndone = 0;
    for (int k = 0; k < 40 && ndone < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc - t0 == 2) begin
        quoteint  = 4'd6;
        divisor   = 4'd7;
        remainder = 8'd8;
      end
      if (done) begin
        ndone++;
        pop_check($sformatf("b2b%0d", ndone));
        if (ndone == 1) begin
          check("b2b first latency", cyc - t0, 9);
          t1 = cyc;
        end else begin
          check("b2b spacing", cyc - t1, 11);
          start = 1'b0;
        end
      end
    end
    check("b2b done count", ndone, 2);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b stopped", int'(busy), 0);

    // Abort an operation with reset 4 cycles after start.
    quoteint  = 4'd7;
    divisor   = 4'd7;
    remainder = 8'd7;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort dividend", int'(dividend), 0);
    check("abort overflow", int'(overflow), 0);
    check("abort busy", int'(busy), 0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no done", ndone, 0);
    last_div = 8'd0;
    last_ovf = 1'b0;
    run_op(4'd2, 4'd2, 8'd0, 8'd4, 1'b0, 1'b0, "post-abort");

    // Divider round trip: N = Q*D + R with R < D and Q < 16.
    for (int i = 0; i < 20; i++) begin
      dd = $urandom_range(1, 15);
      nn = $urandom_range(0, (16 * dd - 1 > 255) ? 255 : 16 * dd - 1);
      qq = 4'(nn / dd);
      rr = 8'(nn % dd);
      run_op(qq, 4'(dd), rr, 8'(nn), 1'b0, 1'b0,
             $sformatf("rt%0d n=%0d d=%0d", i, nn, dd));
    end

    check("scoreboard empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
